// File: rtl/engine_access_arbiter_if.sv
// engine_access_arbiter_if: order, dump and engine handshake bundle around the arbiter
interface engine_access_arbiter_if;
   logic        mkt_valid;
   logic [31:0] mkt_data;
   logic        mkt_last;
   logic        mkt_ready;
   logic        bot_valid;
   logic [31:0] bot_data;
   logic        bot_ready;
   logic        dump_req;
   logic        dump_ack;
   logic        eng_busy;
   logic        eng_valid;
   logic [31:0] eng_data;
   logic        eng_dump_start;
   logic [2:0]  o_state;
   logic [15:0] o_issue_count;
   modport master (
      input  mkt_valid, mkt_data, mkt_last, bot_valid, bot_data, dump_req, eng_busy,
      output mkt_ready, bot_ready, dump_ack, eng_valid, eng_data, eng_dump_start, o_state, o_issue_count
   );
   modport slave (
      output mkt_valid, mkt_data, mkt_last, bot_valid, bot_data, dump_req, eng_busy,
      input  mkt_ready, bot_ready, dump_ack, eng_valid, eng_data, eng_dump_start, o_state, o_issue_count
   );
endinterface

// File: rtl/engine_access_arbiter.sv
// engine_access_arbiter: arbitrates market, bot and book-dump access to the order book engine
module engine_access_arbiter #(
   parameter int MAX_BURST    = 64,
   parameter int DUMP_TIMEOUT = 16
) (
   input logic clk_engine,
   input logic rst_engine,
   engine_access_arbiter_if.master bus
);
   typedef enum logic [2:0] {IDLE = 3'd0, MARKET = 3'd1, BOT = 3'd2, DUMP_START = 3'd3, DUMP_WAIT = 3'd4} state_t;
   localparam int TW = $clog2(DUMP_TIMEOUT + 1);
   state_t        state, state_n;
   logic          last_mkt, last_mkt_n;
   logic          dump_pending, busy_seen, issue_ok, take, dump_issue, dump_done;
   logic [6:0]    burst;
   logic [TW-1:0] wait_cnt;
   // a visible strobe is the gap cycle: nothing issues while the engine is looking at one
   assign issue_ok      = !bus.eng_busy && !bus.eng_valid && !bus.eng_dump_start;
   assign bus.mkt_ready = state == MARKET && issue_ok && bus.mkt_valid;
   assign bus.bot_ready = state == BOT && issue_ok && bus.bot_valid;
   assign take          = bus.mkt_ready || bus.bot_ready;
   assign dump_issue    = state == DUMP_START && issue_ok;
   assign dump_done     = state == DUMP_WAIT && !bus.eng_busy && (busy_seen || wait_cnt == TW'(DUMP_TIMEOUT - 1));
   assign bus.o_state   = state;
   // next-state and grant history
   always_comb begin
      state_n    = state;
      last_mkt_n = last_mkt;
      case (state)
         IDLE:       state_n = dump_pending ? DUMP_START
                             : bus.mkt_valid && (!bus.bot_valid || !last_mkt) ? MARKET
                             : bus.bot_valid ? BOT : IDLE;
         MARKET:     if (bus.mkt_ready && (bus.mkt_last || burst == 7'(MAX_BURST - 1))) begin
                        state_n    = IDLE;
                        last_mkt_n = 1'b1;
                     end
         BOT:        if (bus.bot_ready || !bus.bot_valid) begin
                        state_n    = IDLE;
                        last_mkt_n = bus.bot_ready ? 1'b0 : last_mkt;
                     end
         DUMP_START: state_n = dump_issue ? DUMP_WAIT : DUMP_START;
         DUMP_WAIT:  state_n = dump_done ? IDLE : DUMP_WAIT;
         default:    state_n = IDLE;
      endcase
   end
   // state register; last_grant resets to bot so market wins the first tie
   always_ff @(posedge clk_engine) begin
      if (rst_engine) begin
         state    <= IDLE;
         last_mkt <= 1'b0;
      end else begin
         state    <= state_n;
         last_mkt <= last_mkt_n;
      end
   end
   // engine strobes, issued word, dump bookkeeping and counters
   always_ff @(posedge clk_engine) begin
      if (rst_engine) begin
         dump_pending       <= 1'b0;
         busy_seen          <= 1'b0;
         burst              <= '0;
         wait_cnt           <= '0;
         bus.eng_valid      <= 1'b0;
         bus.eng_data       <= '0;
         bus.eng_dump_start <= 1'b0;
         bus.dump_ack       <= 1'b0;
         bus.o_issue_count  <= '0;
      end else begin
         dump_pending       <= bus.dump_req || (dump_pending && !dump_issue);
         busy_seen          <= state == DUMP_WAIT && (busy_seen || bus.eng_busy);
         burst              <= state == MARKET ? burst + 7'(bus.mkt_ready) : 7'd0;
         wait_cnt           <= state == DUMP_WAIT ? wait_cnt + TW'(1) : '0;
         bus.eng_valid      <= take;
         bus.eng_data       <= bus.mkt_ready ? bus.mkt_data : bus.bot_ready ? bus.bot_data : bus.eng_data;
         bus.eng_dump_start <= dump_issue;
         bus.dump_ack       <= dump_done;
         bus.o_issue_count  <= bus.o_issue_count + 16'(take);
      end
   end
endmodule

// File: doc/engine_access_arbiter.md
ENGINE_ACCESS_ARBITER -- requirements
Module: engine_access_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 64: max market orders issued per market grant.
REQ-002 Parameter DUMP_TIMEOUT, default 16: cycles DUMP_WAIT waits for eng_busy to rise.
REQ-003 Ports:
clk_engine  in  1  engine clock; all logic on rising edge.
rst_engine  in  1  synchronous, active-high reset.
mkt_valid  in  1  market order available (input FIFO not empty).
mkt_data  in  32  market order {price[31:16], is_buy[15], is_bot[14], qty[13:0]}.
mkt_last  in  1  mkt_data is last order of its UDP packet.
mkt_ready  out  1  market order consumed this cycle.
bot_valid  in  1  bot order pending.
bot_data  in  32  bot order, same format.
bot_ready  out  1  bot order consumed this cycle.
dump_req  in  1  book-dump request, single-cycle pulse.
dump_ack  out  1  one-cycle pulse, dump complete.
eng_busy  in  1  order book engine busy.
eng_valid  out  1  one-cycle order strobe to engine.
eng_data  out  32  order to engine.
eng_dump_start  out  1  one-cycle dump strobe to engine.
o_state  out  3  current FSM state encoding.
o_issue_count  out  16  orders issued since reset, wraps 0xFFFF->0.

Function
REQ-004 States: IDLE=0, MARKET=1, BOT=2, DUMP_START=3, DUMP_WAIT=4; o_state mirrors the register.
REQ-005 issue_ok = !eng_busy && !gap; gap is a 1-cycle flag set the cycle after any eng_valid or eng_dump_start.
REQ-006 mkt_ready = (state==MARKET) && issue_ok && mkt_valid; bot_ready = (state==BOT) && issue_ok && bot_valid; both combinational.
REQ-007 Transfer on ready: next cycle eng_valid=1, eng_data=consumed word unmodified; latency exactly 1 cycle; o_issue_count increments same cycle as eng_valid.
REQ-008 Never two eng_valid/eng_dump_start in consecutive cycles; never while eng_busy was 1 the previous cycle.
REQ-009 dump_req sets sticky dump_pending; repeated pulses while pending coalesce; cleared when eng_dump_start issues.
REQ-010 IDLE arbitration, highest first: dump_pending -> DUMP_START; else round-robin market vs bot by last_grant; a sole valid requester wins; nothing valid stays IDLE.
REQ-011 MARKET: grant held until transfer with mkt_last=1 or MAX_BURST transfers, then IDLE, last_grant=market; dump never preempts mid-packet.
REQ-012 MARKET with mkt_valid=0 waits indefinitely (packet still streaming).
REQ-013 BOT: exactly one transfer, then IDLE, last_grant=bot; bot_valid dropping before transfer returns to IDLE with no issue.
REQ-014 DUMP_START: on issue_ok assert eng_dump_start one cycle, go DUMP_WAIT.
REQ-015 DUMP_WAIT: wait for eng_busy=1 then eng_busy=0, then pulse dump_ack, go IDLE; if eng_busy not seen high within DUMP_TIMEOUT cycles, pulse dump_ack and go IDLE.
REQ-016 dump_req during DUMP_START/DUMP_WAIT re-sets dump_pending, causing a second dump.
REQ-017 Burst counter 7 bits, clears on entering MARKET.

Reset
REQ-018 rst_engine=1 next edge: state=IDLE, all outputs 0, eng_data=0, o_issue_count=0, gap=0, dump_pending=0, last_grant=bot (market wins first tie).
REQ-019 Reset mid-operation aborts: no eng_valid, eng_dump_start or dump_ack the cycle after reset; in-flight words discarded.

Verification
REQ-020 Market packet orders 0x0064_800A, 0x006E_0005 (last), eng_busy=0 -> eng_valid with those words, separated by >=1 idle cycle, o_issue_count=2, return IDLE.
REQ-021 mkt_valid and bot_valid both high from reset, single-order packets -> grants alternate market, bot, market; each eng_valid 1 cycle after its ready.
REQ-022 dump_req mid 3-order packet -> all 3 orders issue first, then eng_dump_start; engine busy 10 cycles -> dump_ack 1 cycle after eng_busy falls.
REQ-023 dump_req, eng_busy held 0 -> eng_dump_start, dump_ack exactly DUMP_TIMEOUT cycles later.
REQ-024 eng_busy=1 for 20 cycles with market pending -> mkt_ready=0 throughout; first issue 1 cycle after eng_busy drops.
REQ-025 70-order packet, MAX_BURST=64 -> 64 issued, IDLE, pending bot served, remaining 6 issued; rst_engine asserted mid-burst -> all outputs 0 next cycle.
